// File: rtl/wishbone_cmd_master_pkg.sv
// Shared definitions for the WISHBONE command master.
//   - Bus widths (16-bit address, 8-bit data)
//   - Per-command status codes reported on status_o
//   - FSM state encoding
package wishbone_cmd_master_pkg;

  localparam int unsigned WB_ADR_W = 16;
  localparam int unsigned WB_DAT_W = 8;

  typedef enum logic [1:0] {
    WBM_ST_OK  = 2'b00,
    WBM_ST_ERR = 2'b01,
    WBM_ST_RTY = 2'b10,
    WBM_ST_TMO = 2'b11
  } wbm_status_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STROBE,
    ST_GAP,
    ST_RETRY_WAIT,
    ST_FINISH
  } wbm_state_e;

endpackage

// File: rtl/wishbone_cmd_master_beat_timer.sv
// wbm_beat_timer: loadable down-counter shared by the no-response timeout
// and the retry gap. Load has priority over decrement; the counter holds at
// zero.
//   clk_i     system clock
//   rst       synchronous active-high reset (counter -> 0)
//   load      load load_val this cycle
//   load_val  value to load
//   dec       decrement by one (ignored when load or already zero)
//   zero      counter currently equals zero
module wbm_beat_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk_i) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/wishbone_cmd_master.sv
// wishbone_cmd_master: classic-cycle WISHBONE initiator that expands one
// host command into a burst of byte transfers with address auto-increment,
// handling ack/err/rty, bounded retry and a no-response timeout.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   req_i/req_wr_i/req_adr_i/req_len_i  command (accepted when idle)
//   wdat_i, wdat_rd_o       write data source and its pop strobe
//   rdat_o, rdat_valid_o    read data and its strobe
//   busy_o, done_o          command in progress / end-of-command strobe
//   status_o, beats_done_o  result of the last command
//   cyc_o/stb_o/wr_o/adr_o/dat_o/dat_i/ack_i/err_i/rty_i  WISHBONE master
module wishbone_cmd_master
  import wishbone_cmd_master_pkg::*;
#(
  parameter int unsigned LEN_BITS       = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned RETRY_GAP      = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  input  logic                req_wr_i,
  input  logic [15:0]         req_adr_i,
  input  logic [LEN_BITS-1:0] req_len_i,
  input  logic [7:0]          wdat_i,
  output logic                wdat_rd_o,
  output logic [7:0]          rdat_o,
  output logic                rdat_valid_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [1:0]          status_o,
  output logic [LEN_BITS:0]   beats_done_o,
  output logic                cyc_o,
  output logic                stb_o,
  output logic                wr_o,
  output logic [15:0]         adr_o,
  output logic [7:0]          dat_o,
  input  logic [7:0]          dat_i,
  input  logic                ack_i,
  input  logic                err_i,
  input  logic                rty_i
);

  localparam int unsigned TMR_MAX = (TIMEOUT_CYCLES > RETRY_GAP) ? TIMEOUT_CYCLES : RETRY_GAP;
  localparam int unsigned TW      = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int unsigned RW      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  // The timer is loaded with N-1 and expires on the cycle it reads zero,
  // so the state it guards lasts exactly N cycles.
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD = TW'(RETRY_GAP - 1);
  localparam logic [RW-1:0] RTY_MAX  = RW'(MAX_RETRY);

  wbm_state_e          state;
  logic [LEN_BITS:0]   len_r;
  logic [LEN_BITS:0]   beats;
  logic [LEN_BITS:0]   beats_nxt;
  logic [RW-1:0]       retry_cnt;

  logic                tmr_load;
  logic [TW-1:0]       tmr_val;
  logic                tmr_dec;
  logic                tmr_zero;

  logic                take_err;
  logic                take_rty;
  logic                take_ack;
  logic                rty_exh;
  logic                last_ack;
  logic                tmo;
  logic                fin;
  wbm_status_e         fin_status;

  assign beats_nxt = beats + 1'b1;

  // Response decode, priority err > rty > ack; ignored outside STROBE.
  always_comb begin
    take_err   = (state == ST_STROBE) && err_i;
    take_rty   = (state == ST_STROBE) && !err_i && rty_i;
    take_ack   = (state == ST_STROBE) && !err_i && !rty_i && ack_i;
    tmo        = (state == ST_STROBE) && !err_i && !rty_i && !ack_i && tmr_zero;
    rty_exh    = take_rty && (retry_cnt == RTY_MAX);
    last_ack   = take_ack && (beats_nxt == len_r);
    fin        = take_err || rty_exh || last_ack || tmo;
    fin_status = WBM_ST_OK;
    if (take_err) begin
      fin_status = WBM_ST_ERR;
    end else if (rty_exh) begin
      fin_status = WBM_ST_RTY;
    end else if (tmo) begin
      fin_status = WBM_ST_TMO;
    end
  end

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = TMO_LOAD;
    tmr_dec  = 1'b0;
    unique case (state)
      ST_IDLE: tmr_load = req_i;
      ST_STROBE: begin
        if (take_rty && !rty_exh) begin
          tmr_load = 1'b1;
          tmr_val  = GAP_LOAD;
        end else if (!err_i && !rty_i && !ack_i) begin
          tmr_dec = 1'b1;
        end
      end
      ST_GAP: tmr_load = 1'b1;
      ST_RETRY_WAIT: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: ;
    endcase
  end

  wbm_beat_timer #(
    .WIDTH(TW)
  ) u_timer (
    .clk_i    (clk_i),
    .rst      (rst_i),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  assign dat_o = (stb_o && wr_o) ? wdat_i : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      len_r        <= '0;
      beats        <= '0;
      retry_cnt    <= '0;
      wdat_rd_o    <= 1'b0;
      rdat_o       <= '0;
      rdat_valid_o <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      status_o     <= '0;
      beats_done_o <= '0;
      cyc_o        <= 1'b0;
      stb_o        <= 1'b0;
      wr_o         <= 1'b0;
      adr_o        <= '0;
    end else begin
      wdat_rd_o    <= 1'b0;
      rdat_valid_o <= 1'b0;
      done_o       <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (req_i) begin
            wr_o      <= req_wr_i;
            adr_o     <= req_adr_i;
            len_r     <= (req_len_i == '0) ? {1'b1, {LEN_BITS{1'b0}}} : {1'b0, req_len_i};
            beats     <= '0;
            retry_cnt <= '0;
            busy_o    <= 1'b1;
            cyc_o     <= 1'b1;
            stb_o     <= 1'b1;
            state     <= ST_STROBE;
          end
        end
        ST_STROBE: begin
          if (take_ack) begin
            beats     <= beats_nxt;
            adr_o     <= adr_o + 1'b1;
            retry_cnt <= '0;
            if (wr_o) begin
              wdat_rd_o <= 1'b1;
            end else begin
              rdat_o       <= dat_i;
              rdat_valid_o <= 1'b1;
            end
          end
          if (fin) begin
            cyc_o        <= 1'b0;
            stb_o        <= 1'b0;
            wr_o         <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b1;
            status_o     <= fin_status;
            beats_done_o <= take_ack ? beats_nxt : beats;
            state        <= ST_FINISH;
          end else if (take_rty) begin
            retry_cnt <= retry_cnt + 1'b1;
            stb_o     <= 1'b0;
            state     <= ST_RETRY_WAIT;
          end else if (take_ack) begin
            stb_o <= 1'b0;
            state <= ST_GAP;
          end
        end
        ST_GAP: begin
          stb_o <= 1'b1;
          state <= ST_STROBE;
        end
        ST_RETRY_WAIT: begin
          if (tmr_zero) begin
            stb_o <= 1'b1;
            state <= ST_STROBE;
          end
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/wishbone_cmd_master.md
Name: wishbone_cmd_master

Overview:
- Generic WISHBONE initiator (classic cycles, 16-bit address, 8-bit data) that turns a single command into a burst of byte transfers with address auto-increment.
- Sits between a host-side command decoder (USB/I2C/PHY bridge) and the WISHBONE slave blocks: trigger control, scalers, ID registers.
- Handles the slave's ack/err/rty responses, bounded retry and a no-response timeout, then reports one status word per command.

Parameters:
- LEN_BITS, 8, width of beat count; a length of 0 means 2^LEN_BITS beats.
- TIMEOUT_CYCLES, 255, maximum cycles stb_o is held without ack/err/rty before abort; must be >= 1.
- MAX_RETRY, 3, number of rty responses tolerated per beat before abort; 0 means abort on the first rty.
- RETRY_GAP, 4, idle cycles between an rty and re-strobe of the same beat; must be >= 1.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- req_i  in  1  command strobe; accepted only when busy_o=0
- req_wr_i  in  1  1=write burst, 0=read burst
- req_adr_i  in  16  start address
- req_len_i  in  LEN_BITS  beat count (0 means 2^LEN_BITS)
- wdat_i  in  8  write data for the current beat
- wdat_rd_o  out  1  one-cycle pop of wdat_i on each acked write beat
- rdat_o  out  8  read data
- rdat_valid_o  out  1  one-cycle strobe per acked read beat
- busy_o  out  1  command in progress
- done_o  out  1  one-cycle end-of-command strobe
- status_o  out  2  00 OK, 01 ERR, 10 RETRY_EXHAUSTED, 11 TIMEOUT; valid from done_o until the next accept
- beats_done_o  out  LEN_BITS+1  number of beats acked in the last command
- cyc_o  out  1  WISHBONE cycle
- stb_o  out  1  WISHBONE strobe
- wr_o  out  1  WISHBONE write enable
- adr_o  out  16  WISHBONE address
- dat_o  out  8  WISHBONE write data
- dat_i  in  8  WISHBONE read data
- ack_i  in  1  WISHBONE acknowledge
- err_i  in  1  WISHBONE error
- rty_i  in  1  WISHBONE retry

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is synchronous, active-high, highest priority.
- Reset values: all outputs 0 (cyc_o, stb_o, wr_o, adr_o, dat_o, wdat_rd_o, rdat_o, rdat_valid_o, busy_o, done_o, status_o, beats_done_o). State goes to IDLE.
- Reset mid-burst: cyc_o and stb_o drop the cycle after rst_i is sampled. No done_o is produced. The command is lost.
- FSM states: IDLE, STROBE, GAP, RETRY_WAIT, FINISH.
- IDLE: on req_i, latch wr, address and length (0 -> 2^LEN_BITS). Clear beats and retry counters. Set busy_o. Go to STROBE; cyc_o, stb_o and adr_o are asserted the next cycle (1-cycle accept latency). req_i while busy_o=1 is ignored.
- STROBE: cyc_o=1, stb_o=1, wr_o and adr_o stable. dat_o is driven combinationally from wdat_i during write beats. Timeout counter increments each cycle.
- Response priority, same cycle: err_i > rty_i > ack_i.
- ack_i: increment beats_done. Read beats pulse rdat_valid_o and register rdat_o<=dat_i. Write beats pulse wdat_rd_o. Address +1, 16-bit wrap 0xFFFF->0x0000. Reset retry and timeout counters. If last beat, go to FINISH with status OK; otherwise go to GAP.
- err_i: go to FINISH with status ERR. The beat is not counted.
- rty_i: if retry count = MAX_RETRY, go to FINISH with RETRY_EXHAUSTED. Otherwise increment the retry count, drop stb_o (cyc_o stays 1) and go to RETRY_WAIT.
- Timeout: timeout counter reaching TIMEOUT_CYCLES with no response goes to FINISH with TIMEOUT.
- GAP: stb_o=0, cyc_o=1 for exactly one cycle, then STROBE. This guarantees a registered-ack slave has deasserted ack before the next beat.
- RETRY_WAIT: stb_o=0 for RETRY_GAP cycles, then STROBE with the same address and data.
- FINISH: cyc_o=0, stb_o=0, done_o=1 for one cycle. status_o and beats_done_o are updated. busy_o clears the same cycle. Next state is IDLE, so a new req_i can be accepted on the following cycle.
- Responses arriving while stb_o=0 are ignored.

Decomposition:
- Shared package/header (alongside the existing WISHBONE interface definitions):
  - status codes WBM_ST_OK/ERR/RTY/TMO
  - FSM state encodings
  - WISHBONE address/data widths (16/8)
- One natural sub-module: wbm_beat_timer, a loadable down-counter used for both the timeout and the retry gap (load, decrement, zero flag).

Test Plan:
- Single write, 0x5A to 0x007F, slave acks on the 2nd strobe cycle -> one wdat_rd_o pulse, dat_o=0x5A with wr_o=1 at ack, done_o with status 00, beats_done=1, cyc_o low in the FINISH cycle.
- Read burst of 4 from 0x0064, slave returns 0x11,0x22,0x33,0x44 -> adr_o steps 0x64..0x67 with one stb_o-low gap between beats, 4 rdat_valid_o pulses carrying those values, status 00, beats_done=4.
- Read burst of 3 from 0xFFFF -> adr_o sequence 0xFFFF,0x0000,0x0001; status 00.
- Write burst of 4, err_i on beat 3 -> done_o with status 01, beats_done=2, exactly 2 wdat_rd_o pulses, no further strobes.
- rty_i on 3 consecutive attempts then ack -> same address re-strobed after each 4-cycle gap, status 00. rty_i on 4 attempts -> status 10, beats_done=0.
- Slave never responds -> stb_o held 255 cycles, then done_o with status 11. Separately, assert rst_i mid-burst -> all outputs 0 the next cycle and no done_o.
